// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column strobe, samples the rows,
// debounces whole-scan results and reports newly accepted keys with n-key lockout.
module keypad_scanner #(
  parameter int SCAN_DIV = 65536,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STB_W = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {RES_NONE, RES_ONE, RES_MULTI} res_t;

  logic [3:0]       rowMeta, rowS;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [1:0]       colIdx, nextIdx;
  res_t             accKind, mergeKind, scanKind, prevKind;
  logic [3:0]       accCode, mergeCode, scanCode, prevCode;
  logic             scanReady;
  logic [STB_W-1:0] stable, nextStable;
  logic [2:0]       lowCount;
  logic [1:0]       rowIdx;
  logic             same, reach;

  assign tick    = (cnt == CNT_W'(SCAN_DIV - 1));
  assign nextIdx = colIdx + 2'd1;

  always_comb begin
    lowCount = 3'd0;
    rowIdx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!rowS[i]) begin
        lowCount = lowCount + 3'd1;
        rowIdx   = 2'(i);
      end
    end
  end

  // A hit in a second column, or several rows low at once, makes the whole scan ambiguous.
  always_comb begin
    mergeKind = accKind;
    mergeCode = accCode;
    if (lowCount >= 3'd2 || (lowCount == 3'd1 && accKind != RES_NONE)) begin
      mergeKind = RES_MULTI;
    end else if (lowCount == 3'd1) begin
      mergeKind = RES_ONE;
      mergeCode = {colIdx, rowIdx};
    end
  end

  always_comb begin
    same = (scanKind == prevKind) && (scanKind != RES_ONE || scanCode == prevCode);
    if (!same) begin
      nextStable = STB_W'(1);
      reach      = (DEBOUNCE == 1);
    end else begin
      nextStable = (stable == STB_W'(DEBOUNCE)) ? stable : stable + STB_W'(1);
      reach      = (stable == STB_W'(DEBOUNCE - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rowMeta   <= 4'hF;
      rowS      <= 4'hF;
      cnt       <= '0;
      colIdx    <= 2'd0;
      col       <= 4'b1110;
      accKind   <= RES_NONE;
      accCode   <= 4'd0;
      scanKind  <= RES_NONE;
      scanCode  <= 4'd0;
      scanReady <= 1'b0;
    end else begin
      rowMeta   <= row;
      rowS      <= rowMeta;
      scanReady <= 1'b0;
      if (tick) begin
        cnt    <= '0;
        colIdx <= nextIdx;
        col    <= ~(4'b0001 << nextIdx);
        if (colIdx == 2'd3) begin
          scanKind  <= mergeKind;
          scanCode  <= mergeCode;
          scanReady <= 1'b1;
          accKind   <= RES_NONE;
          accCode   <= 4'd0;
        end else begin
          accKind <= mergeKind;
          accCode <= mergeCode;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Once a key is held, only a debounced empty scan re-arms acceptance (n-key lockout).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prevKind  <= RES_NONE;
      prevCode  <= 4'd0;
      stable    <= '0;
      key       <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (scanReady) begin
        stable   <= nextStable;
        prevKind <= scanKind;
        prevCode <= scanCode;
        if (scanKind == RES_ONE && reach && !key_held) begin
          key       <= scanCode;
          key_valid <= 1'b1;
          key_held  <= 1'b1;
        end else if (scanKind == RES_NONE && nextStable == STB_W'(DEBOUNCE)) begin
          key_held <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational keypad model driven by the strobes.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam logic [15:0] K3  = 16'h0008;
  localparam logic [15:0] K6  = 16'h0040;
  localparam logic [15:0] K9  = 16'h0200;
  localparam logic [15:0] K12 = 16'h1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row, col, key;
  logic        key_valid, key_held;
  logic [15:0] pressed = '0;
  int          edgeNo;
  int          pulses = 0;
  int          pulseBase = 0;
  int          checks = 0;
  int          errors = 0;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .key(key), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // A pressed key pulls its row low only while its column is strobed.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[4*c + r] && !col[c]) row[r] = 1'b0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) edgeNo <= -1;
    else     edgeNo <= edgeNo + 1;
  end

  always @(posedge clk) if (key_valid === 1'b1) pulses <= pulses + 1;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] keys);
    pressed = keys;
  endtask

  task automatic doReset(input logic [15:0] keys);
    rst = 1'b1;
    pressed = keys;
    repeat (2) @(negedge clk);
    pulseBase = pulses;
    rst = 1'b0;
  endtask

  task automatic waitEdge(input int n);
    int guard = 0;
    while (edgeNo < n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) checkOutput("edge_timeout", 16'(edgeNo), 16'(n));
  endtask

  initial begin
    $display("[TB] scenario 1: reset and strobe sequence");
    repeat (2) @(negedge clk);
    checkOutput("rst_col", 16'(col), 16'hE);
    checkOutput("rst_key", 16'(key), 16'h0);
    checkOutput("rst_valid", 16'(key_valid), 16'h0);
    checkOutput("rst_held", 16'(key_held), 16'h0);
    pulseBase = pulses;
    rst = 1'b0;
    waitEdge(2);  checkOutput("s1_col_e2", 16'(col), 16'hE);
    waitEdge(3);  checkOutput("s1_col_e3", 16'(col), 16'hD);
    waitEdge(14); checkOutput("s1_col_e14", 16'(col), 16'h7);
    waitEdge(15); checkOutput("s1_col_e15", 16'(col), 16'hE);
    waitEdge(64); checkOutput("s1_pulses", 16'(pulses - pulseBase), 16'd0);
    checkOutput("s1_held", 16'(key_held), 16'h0);

    $display("[TB] scenario 2/3: single press then release");
    doReset(K6);
    waitEdge(47); checkOutput("s2_valid_e47", 16'(key_valid), 16'h0);
    waitEdge(48); checkOutput("s2_valid_e48", 16'(key_valid), 16'h1);
    checkOutput("s2_key", 16'(key), 16'h6);
    checkOutput("s2_held", 16'(key_held), 16'h1);
    waitEdge(49); checkOutput("s2_valid_e49", 16'(key_valid), 16'h0);
    waitEdge(96); checkOutput("s2_pulses", 16'(pulses - pulseBase), 16'd1);
    applyStimulus('0);
    waitEdge(143); checkOutput("s3_held_e143", 16'(key_held), 16'h1);
    waitEdge(144); checkOutput("s3_held_e144", 16'(key_held), 16'h0);
    checkOutput("s3_key", 16'(key), 16'h6);
    waitEdge(170); checkOutput("s3_pulses", 16'(pulses - pulseBase), 16'd1);

    $display("[TB] scenario 4: bounce");
    doReset(K6);
    waitEdge(15); applyStimulus('0);
    waitEdge(31); applyStimulus(K6);
    waitEdge(47); applyStimulus('0);
    waitEdge(63); applyStimulus(K6);
    waitEdge(111); checkOutput("s4_pulses_bounce", 16'(pulses - pulseBase), 16'd0);
    checkOutput("s4_valid_e111", 16'(key_valid), 16'h0);
    waitEdge(112); checkOutput("s4_valid_e112", 16'(key_valid), 16'h1);
    checkOutput("s4_key", 16'(key), 16'h6);
    waitEdge(130); checkOutput("s4_pulses", 16'(pulses - pulseBase), 16'd1);

    $display("[TB] scenario 5: multiple keys and lockout");
    doReset(K3 | K12);
    waitEdge(79); checkOutput("s5_multi_pulses", 16'(pulses - pulseBase), 16'd0);
    checkOutput("s5_multi_held", 16'(key_held), 16'h0);
    applyStimulus(K6);
    waitEdge(127); checkOutput("s5_valid_e127", 16'(key_valid), 16'h0);
    waitEdge(128); checkOutput("s5_valid_e128", 16'(key_valid), 16'h1);
    checkOutput("s5_key", 16'(key), 16'h6);
    waitEdge(143); applyStimulus(K6 | K9);
    waitEdge(208); checkOutput("s5_lock_held", 16'(key_held), 16'h1);
    checkOutput("s5_lock_key", 16'(key), 16'h6);
    checkOutput("s5_lock_pulses", 16'(pulses - pulseBase), 16'd1);

    $display("[TB] scenario 6: async reset mid-press");
    doReset(K6);
    waitEdge(48); checkOutput("s6_valid_pre", 16'(key_valid), 16'h1);
    #1 rst = 1'b1;
    #1;
    checkOutput("s6_async_valid", 16'(key_valid), 16'h0);
    checkOutput("s6_async_key", 16'(key), 16'h0);
    checkOutput("s6_async_held", 16'(key_held), 16'h0);
    checkOutput("s6_async_col", 16'(col), 16'hE);
    @(negedge clk);
    pulseBase = pulses;
    rst = 1'b0;
    waitEdge(47); checkOutput("s6_valid_e47", 16'(key_valid), 16'h0);
    waitEdge(48); checkOutput("s6_valid_e48", 16'(key_valid), 16'h1);
    checkOutput("s6_key", 16'(key), 16'h6);
    checkOutput("s6_held", 16'(key_held), 16'h1);
    waitEdge(60); checkOutput("s6_pulses", 16'(pulses - pulseBase), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad by strobing one column at a time and reading back the four rows. It debounces the result over several complete scans and reports each new press as a 4-bit key code with a one-cycle valid pulse. It is the input-side counterpart of the multiplexed seven-segment driver: it drives a rotating active-low strobe and samples lines instead of driving them. Its key codes feed the digit registers shown on the display.

## Interface
- SCAN_DIV, 65536: clock cycles per column slot; must be ≥ 4.
- DEBOUNCE, 4: consecutive identical complete scans needed to accept a change; must be ≥ 1.

- clk  in  1  system clock.
- rst  in  1  reset. Asynchronous and active-high: asserting it clears all state at once, without waiting for a clock edge.
- row  in  4  keypad rows, active-low (pulled up). Asynchronous to clk.
- col  out  4  column strobes, active-low. Exactly one bit is low at any time.
- key  out  4  code of the last accepted key, = 4*col_idx + row_idx.
- key_valid  out  1  high for exactly one cycle when a new key is accepted.
- key_held  out  1  high while the accepted key is still debounced-pressed.

## Operation
- **Reset values:** col=4'b1110 (col_idx 0), key=0, key_valid=0, key_held=0. Prescaler=0, previous-scan result=NONE, stable count=0, scan accumulator cleared.
- **Row synchronizer:** row passes through 2 flops, giving row_s. All sampling uses row_s.
- **Prescaler:** counts 0..SCAN_DIV-1, width clog2(SCAN_DIV), and wraps. tick = (count == SCAN_DIV-1).
- **Column sequence:** on each tick edge, col advances 1110 → 1101 → 1011 → 0111 → 1110 (col_idx 0→1→2→3→0).
- **Column sample:** on each tick edge, row_s is sampled for the column currently strobed.
  - No row bits low: nothing is recorded.
  - Exactly one row bit low: a hit with code 4*col_idx + row_idx is recorded (row_idx = index of the low bit).
  - Two or more row bits low: the scan is marked MULTI.
- **Scan result:** one of NONE, ONE(code), or MULTI.
  - A second hit in a different column within the same scan also makes it MULTI.
  - The result is latched on the tick edge of col_idx 3, including that column's sample. The accumulator is cleared for the next scan.
- **Debounce update:** on the edge after a scan result is latched.
  - Result equals previous result: stable count increments, saturating at DEBOUNCE.
  - Result differs: stable count is set to 1 and the previous result is updated.
- **Accept, in the same update edge:**
  - stable count reaches DEBOUNCE on this edge, result ONE(c), and key_held=0: set key=c, key_valid=1, key_held=1.
  - stable count == DEBOUNCE and result NONE: set key_held=0; key keeps its value.
  - Result MULTI: no change to key or key_held.
  - Result ONE(d) while key_held=1 (including d≠key): no new pulse. This is n-key lockout; a debounced NONE is required before the next acceptance.
- key_valid clears on the next edge unconditionally.

## Timing
- Edges are numbered from edge 0, the first rising clk after rst deasserts.
- One full scan takes 4*SCAN_DIV cycles.
- Scan k (k = 1, 2, …) latches on edge 4*SCAN_DIV*k - 1. Its debounce update happens on edge 4*SCAN_DIV*k.
- For a key held steadily from reset, key_valid is set on edge 4*SCAN_DIV*DEBOUNCE and cleared on the following edge.
- A row change must be present 2 edges before a tick edge to be seen in that slot.
- Worst-case press-to-valid latency is (DEBOUNCE+1)*4*SCAN_DIV + 3 cycles.
- key, key_valid and key_held change only on the update edge, or asynchronously on rst.
- **Reset mid-scan or mid-debounce:** all state returns to reset values immediately. A key still held after release is re-accepted after DEBOUNCE fresh complete scans.
- **rst asserted during a key_valid cycle:** key_valid drops immediately.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE=3 (16 cycles per scan).
1. **Reset and strobe sequence.** Assert rst with row=4'hF, then release. Required: col=1110, key=0, key_valid=0, key_held=0. col=1101 after edge 3 and returns to 1110 after edge 15. No key_valid ever pulses.
2. **Single press.** Drive row=1011 whenever col=1101 (key 6) from reset. Required: key_valid=1 for exactly one cycle after edge 48, key=6, key_held=1, and no further pulse while held.
3. **Release.** From scenario 2, set row=4'hF permanently. Required: key_held falls on the 3rd NONE-scan update edge, key stays 6, and key_valid stays 0.
4. **Bounce.** Alternate key 6 pressed/released on successive scans for 5 scans, then hold it. Required: no pulse during the bounce; exactly one pulse with key=6 after 3 stable scans.
5. **Multiple keys and lockout.** Press keys 3 and 12 together (different columns). Required: no key_valid. Then press key 6 alone until accepted and add key 9. Required: key_held stays 1, key stays 6, and no new pulse.
6. **Async reset mid-press.** Assert rst between clk edges while key 6 is held and key_held=1. Required: outputs clear before the next edge. After rst releases with key still held, one pulse with key=6 after edge 48.
